// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between N_REQ byte producers; gnt/start_send one cycle after req is sampled.
// Backpressure: a new grant needs enable high and tx_busy low in IDLE; requests seen outside IDLE are ignored.
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int CLKS_PER_BIT = 434,
  parameter int START_TMO    = 16,
  parameter int FRAME_BITS   = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               tx_busy,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               start_send,
  output logic [7:0]         in_data,
  output logic               err,
  output logic [1:0]         owner
);

  localparam int FRAME_TMO = FRAME_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(FRAME_TMO + 1);

  localparam logic [TW-1:0] START_LAST = TW'(START_TMO - 1);
  localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_TMO - 1);
  localparam logic [TW-1:0] TMR_MAX    = {TW{1'b1}};

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [1:0]    state;
  logic [1:0]    last_grant;
  logic [TW-1:0] timer;
  logic [3:0]    req_pad;
  logic [31:0]   data_pad;
  logic [1:0]    pick;
  logic          pick_vld;
  logic [2:0]    scan_sum;
  logic [1:0]    scan_idx;
  logic          start_timeout;
  logic          frame_timeout;

  assign req_pad  = 4'(req);
  assign data_pad = 32'(req_data);

  // First requester found scanning upward from the one after the last served.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_sum = {1'b0, last_grant} + 3'(k);
      if (scan_sum >= 3'(N_REQ)) scan_sum = scan_sum - 3'(N_REQ);
      scan_idx = scan_sum[1:0];
      if (!pick_vld && req_pad[scan_idx]) begin
        pick     = scan_idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign start_timeout = (state == WAIT_BUSY) && !tx_busy && (timer == START_LAST);
  assign frame_timeout = (state == WAIT_DONE) && tx_busy && (timer == FRAME_LAST);
  assign start_send    = (state == START);
  assign err           = start_timeout | frame_timeout;

  for (genvar g = 0; g < N_REQ; g++) begin : g_per_req
    assign gnt[g]  = start_send && (owner == 2'(g));
    assign done[g] = (state == WAIT_DONE) && !tx_busy && (owner == 2'(g));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 2'(N_REQ - 1);
      owner      <= '0;
      in_data    <= 8'h00;
      timer      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && pick_vld && !tx_busy) begin
            owner   <= pick;
            in_data <= data_pad[{pick, 3'b000} +: 8];
            state   <= START;
          end
        end
        START: begin
          timer <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            timer <= '0;
            state <= WAIT_DONE;
          end else if (start_timeout) begin
            last_grant <= owner;
            state      <= IDLE;
          end else if (timer != TMR_MAX) begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_DONE: begin
          // A timed-out frame still advances the pointer so a stuck TX cannot starve others.
          if (!tx_busy || frame_timeout) begin
            last_grant <= owner;
            state      <= IDLE;
          end else if (timer != TMR_MAX) begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
